// File: rtl/qs_pkg.sv
// Shared types and sizing for the quicksort bank scheduler.
package qs_pkg;

  localparam int BANK_N = 2;
  localparam int N      = 16;
  localparam int BANK_W = $clog2(BANK_N);
  localparam int N_W    = $clog2(N);

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_LOADING   = 3'd1,
    ST_LOADED    = 3'd2,
    ST_SORTING   = 3'd3,
    ST_SORTED    = 3'd4,
    ST_UNLOADING = 3'd5
  } bank_status_t;

  typedef logic [BANK_W-1:0] bank_id_t;
  typedef logic [N_W-1:0]    bank_n_t;

  // n holds the last valid index of the bank (count-1).
  typedef struct packed {
    bank_status_t status;
    bank_n_t      n;
    logic         err;
  } bank_state_t;

endpackage

// File: rtl/qs_bank_stage_ptr.sv
// Per-stage round-robin pointer, busy flag and start/done legality check.
// A stage is offered the bank under its pointer when that bank holds REQ_ST;
// a legal start moves the bank to BUSY_ST, a legal done moves it to DONE_ST
// and advances the pointer.
module qs_bank_stage_ptr
  import qs_pkg::*;
#(
  parameter bank_status_t REQ_ST  = ST_READY,
  parameter bank_status_t BUSY_ST = ST_LOADING,
  parameter bank_status_t DONE_ST = ST_LOADED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_done,
  input  bank_status_t i_status_nxt,
  output bank_id_t     o_ptr_r,
  output bank_id_t     o_ptr_nxt,
  output logic         o_vld_r,
  output logic         o_wr_en,
  output bank_status_t o_wr_status,
  output logic         o_done_ok,
  output logic         o_viol
);

  logic     r_busy;
  logic     r_vld;
  bank_id_t r_ptr;

  logic     w_start_ok;
  logic     w_done_ok;
  logic     w_busy_nxt;
  logic     w_vld_nxt;

  // Legality: start needs an offer and nothing in flight, done needs something
  // in flight; both in one cycle is never legal and changes nothing.
  always_comb begin
    w_start_ok  = i_start && !i_done && r_vld && !r_busy;
    w_done_ok   = i_done && !i_start && r_busy;
    o_viol      = (i_start || i_done) && !(w_start_ok || w_done_ok);
    o_wr_en     = w_start_ok || w_done_ok;
    o_wr_status = w_done_ok ? DONE_ST : BUSY_ST;
    o_done_ok   = w_done_ok;
    o_ptr_nxt   = w_done_ok ? r_ptr + bank_id_t'(1) : r_ptr;
    w_busy_nxt  = w_start_ok ? 1'b1 : (w_done_ok ? 1'b0 : r_busy);
  end

  // Offer is computed from the post-update status of the bank the pointer will
  // point at, kept separate from the write path to avoid a combinational loop.
  assign w_vld_nxt = (i_status_nxt == REQ_ST) && !w_busy_nxt;

  assign o_ptr_r = r_ptr;
  assign o_vld_r = r_vld;

  // Pointer, busy and offer registers; only the loader is offered a bank out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_busy <= 1'b0;
      r_vld  <= (REQ_ST == ST_READY);
    end else begin
      r_ptr  <= o_ptr_nxt;
      r_busy <= w_busy_nxt;
      r_vld  <= w_vld_nxt;
    end
  end

endmodule

// File: rtl/qs_bank_ctrl.sv
// Central bank-state scheduler: owns the per-bank status array and hands banks
// round-robin to the enqueue, sort and dequeue stages.
module qs_bank_ctrl
  import qs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              enq_bnk_vld_r,
  output logic [BANK_W-1:0] enq_bnk_idx_r,
  input  logic              enq_start,
  input  logic              enq_done,
  input  logic [N_W-1:0]    enq_n,
  input  logic              enq_err,
  output logic              sort_bnk_vld_r,
  output logic [BANK_W-1:0] sort_bnk_idx_r,
  output logic [N_W-1:0]    sort_bnk_n_r,
  input  logic              sort_start,
  input  logic              sort_done,
  input  logic              sort_err,
  output logic              deq_bnk_vld_r,
  output logic [BANK_W-1:0] deq_bnk_idx_r,
  output logic [N_W-1:0]    deq_bnk_n_r,
  output logic              deq_bnk_err_r,
  input  logic              deq_start,
  input  logic              deq_done,
  output logic              idle_r,
  output logic              proto_err_r
);

  bank_state_t  r_bank [BANK_N];
  bank_state_t  w_bank_nxt [BANK_N];
  logic         w_idle_nxt;

  bank_id_t     w_enq_ptr, w_enq_ptr_nxt;
  bank_id_t     w_sort_ptr, w_sort_ptr_nxt;
  bank_id_t     w_deq_ptr, w_deq_ptr_nxt;
  logic         w_enq_wr_en, w_sort_wr_en, w_deq_wr_en;
  bank_status_t w_enq_wr_st, w_sort_wr_st, w_deq_wr_st;
  logic         w_enq_done_ok, w_sort_done_ok, w_deq_done_ok;
  logic         w_enq_viol, w_sort_viol, w_deq_viol;

  qs_bank_stage_ptr #(
    .REQ_ST (ST_READY),
    .BUSY_ST(ST_LOADING),
    .DONE_ST(ST_LOADED)
  ) u_enq (
    .clk         (clk),
    .rst         (rst),
    .i_start     (enq_start),
    .i_done      (enq_done),
    .i_status_nxt(w_bank_nxt[w_enq_ptr_nxt].status),
    .o_ptr_r     (w_enq_ptr),
    .o_ptr_nxt   (w_enq_ptr_nxt),
    .o_vld_r     (enq_bnk_vld_r),
    .o_wr_en     (w_enq_wr_en),
    .o_wr_status (w_enq_wr_st),
    .o_done_ok   (w_enq_done_ok),
    .o_viol      (w_enq_viol)
  );

  qs_bank_stage_ptr #(
    .REQ_ST (ST_LOADED),
    .BUSY_ST(ST_SORTING),
    .DONE_ST(ST_SORTED)
  ) u_sort (
    .clk         (clk),
    .rst         (rst),
    .i_start     (sort_start),
    .i_done      (sort_done),
    .i_status_nxt(w_bank_nxt[w_sort_ptr_nxt].status),
    .o_ptr_r     (w_sort_ptr),
    .o_ptr_nxt   (w_sort_ptr_nxt),
    .o_vld_r     (sort_bnk_vld_r),
    .o_wr_en     (w_sort_wr_en),
    .o_wr_status (w_sort_wr_st),
    .o_done_ok   (w_sort_done_ok),
    .o_viol      (w_sort_viol)
  );

  qs_bank_stage_ptr #(
    .REQ_ST (ST_SORTED),
    .BUSY_ST(ST_UNLOADING),
    .DONE_ST(ST_READY)
  ) u_deq (
    .clk         (clk),
    .rst         (rst),
    .i_start     (deq_start),
    .i_done      (deq_done),
    .i_status_nxt(w_bank_nxt[w_deq_ptr_nxt].status),
    .o_ptr_r     (w_deq_ptr),
    .o_ptr_nxt   (w_deq_ptr_nxt),
    .o_vld_r     (deq_bnk_vld_r),
    .o_wr_en     (w_deq_wr_en),
    .o_wr_status (w_deq_wr_st),
    .o_done_ok   (w_deq_done_ok),
    .o_viol      (w_deq_viol)
  );

  assign enq_bnk_idx_r  = w_enq_ptr;
  assign sort_bnk_idx_r = w_sort_ptr;
  assign deq_bnk_idx_r  = w_deq_ptr;

  // Apply every stage's legal update; stages always own distinct banks so the writes never collide.
  always_comb begin
    w_bank_nxt = r_bank;
    if (w_enq_wr_en) w_bank_nxt[w_enq_ptr].status = w_enq_wr_st;
    if (w_enq_done_ok) begin
      w_bank_nxt[w_enq_ptr].n   = enq_n;
      w_bank_nxt[w_enq_ptr].err = enq_err;
    end
    if (w_sort_wr_en) w_bank_nxt[w_sort_ptr].status = w_sort_wr_st;
    if (w_sort_done_ok) w_bank_nxt[w_sort_ptr].err = w_bank_nxt[w_sort_ptr].err | sort_err;
    if (w_deq_wr_en) w_bank_nxt[w_deq_ptr].status = w_deq_wr_st;
    if (w_deq_done_ok) w_bank_nxt[w_deq_ptr].err = 1'b0;
  end

  // Idle means every bank is back to READY after this cycle's updates.
  always_comb begin
    w_idle_nxt = 1'b1;
    for (int i = 0; i < BANK_N; i++) begin
      if (w_bank_nxt[i].status != ST_READY) w_idle_nxt = 1'b0;
    end
  end

  // Bank array and registered offer data; protocol error is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BANK_N; i++) begin
        r_bank[i] <= '{status: ST_READY, n: '0, err: 1'b0};
      end
      sort_bnk_n_r  <= '0;
      deq_bnk_n_r   <= '0;
      deq_bnk_err_r <= 1'b0;
      idle_r        <= 1'b1;
      proto_err_r   <= 1'b0;
    end else begin
      r_bank        <= w_bank_nxt;
      sort_bnk_n_r  <= w_bank_nxt[w_sort_ptr_nxt].n;
      deq_bnk_n_r   <= w_bank_nxt[w_deq_ptr_nxt].n;
      deq_bnk_err_r <= w_bank_nxt[w_deq_ptr_nxt].err;
      idle_r        <= w_idle_nxt;
      proto_err_r   <= proto_err_r | w_enq_viol | w_sort_viol | w_deq_viol;
    end
  end

endmodule

// File: tb/tb_qs_bank_ctrl.sv
// Directed self-checking bench for the bank scheduler (BANK_N=2, N=16).
module tb_qs_bank_ctrl;
  import qs_pkg::*;

  logic              clk;
  logic              rst;
  logic              enq_bnk_vld_r;
  logic [BANK_W-1:0] enq_bnk_idx_r;
  logic              enq_start;
  logic              enq_done;
  logic [N_W-1:0]    enq_n;
  logic              enq_err;
  logic              sort_bnk_vld_r;
  logic [BANK_W-1:0] sort_bnk_idx_r;
  logic [N_W-1:0]    sort_bnk_n_r;
  logic              sort_start;
  logic              sort_done;
  logic              sort_err;
  logic              deq_bnk_vld_r;
  logic [BANK_W-1:0] deq_bnk_idx_r;
  logic [N_W-1:0]    deq_bnk_n_r;
  logic              deq_bnk_err_r;
  logic              deq_start;
  logic              deq_done;
  logic              idle_r;
  logic              proto_err_r;

  int checkCount;
  int errorCount;

  qs_bank_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enq_bnk_vld_r (enq_bnk_vld_r),
    .enq_bnk_idx_r (enq_bnk_idx_r),
    .enq_start     (enq_start),
    .enq_done      (enq_done),
    .enq_n         (enq_n),
    .enq_err       (enq_err),
    .sort_bnk_vld_r(sort_bnk_vld_r),
    .sort_bnk_idx_r(sort_bnk_idx_r),
    .sort_bnk_n_r  (sort_bnk_n_r),
    .sort_start    (sort_start),
    .sort_done     (sort_done),
    .sort_err      (sort_err),
    .deq_bnk_vld_r (deq_bnk_vld_r),
    .deq_bnk_idx_r (deq_bnk_idx_r),
    .deq_bnk_n_r   (deq_bnk_n_r),
    .deq_bnk_err_r (deq_bnk_err_r),
    .deq_start     (deq_start),
    .deq_done      (deq_done),
    .idle_r        (idle_r),
    .proto_err_r   (proto_err_r)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle pattern of stage pulses, then return all inputs to idle.
  task automatic applyStimulus(input logic es, input logic ed, input logic [N_W-1:0] en,
                               input logic ee, input logic ss, input logic sd, input logic se,
                               input logic ds, input logic dd);
    enq_start = es; enq_done = ed; enq_n = en; enq_err = ee;
    sort_start = ss; sort_done = sd; sort_err = se;
    deq_start = ds; deq_done = dd;
    tick();
    enq_start = 1'b0; enq_done = 1'b0; enq_n = '0; enq_err = 1'b0;
    sort_start = 1'b0; sort_done = 1'b0; sort_err = 1'b0;
    deq_start = 1'b0; deq_done = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    tick();
    checkCount++; if (enq_bnk_vld_r !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_enq_vld got %0d want 1", enq_bnk_vld_r); end
    checkCount++; if (enq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_enq_idx got %0d want 0", enq_bnk_idx_r); end
    checkCount++; if (sort_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_sort_vld got %0d want 0", sort_bnk_vld_r); end
    checkCount++; if (deq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_deq_vld got %0d want 0", deq_bnk_vld_r); end
    checkCount++; if (idle_r !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_idle got %0d want 1", idle_r); end
    checkCount++; if (proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_proto got %0d want 0", proto_err_r); end
  endtask

  task automatic test_single_flow();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCount++; if (enq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_enq_claimed got %0d want 0", enq_bnk_vld_r); end
    checkCount++; if (idle_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_not_idle got %0d want 0", idle_r); end
    applyStimulus(0, 1, 15, 0, 0, 0, 0, 0, 0);
    checkCount++; if (sort_bnk_vld_r !== 1'b1) begin errorCount++; $display("[TB] FAIL flow_sort_vld got %0d want 1", sort_bnk_vld_r); end
    checkCount++; if (sort_bnk_n_r !== 4'd15) begin errorCount++; $display("[TB] FAIL flow_sort_n got %0d want 15", sort_bnk_n_r); end
    checkCount++; if (enq_bnk_idx_r !== 1'b1 || enq_bnk_vld_r !== 1'b1) begin errorCount++; $display("[TB] FAIL flow_enq_next got idx %0d vld %0d want idx 1 vld 1", enq_bnk_idx_r, enq_bnk_vld_r); end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkCount++; if (sort_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_sort_claimed got %0d want 0", sort_bnk_vld_r); end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkCount++; if (deq_bnk_vld_r !== 1'b1) begin errorCount++; $display("[TB] FAIL flow_deq_vld got %0d want 1", deq_bnk_vld_r); end
    checkCount++; if (deq_bnk_n_r !== 4'd15) begin errorCount++; $display("[TB] FAIL flow_deq_n got %0d want 15", deq_bnk_n_r); end
    checkCount++; if (deq_bnk_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_deq_err got %0d want 0", deq_bnk_err_r); end
    checkCount++; if (sort_bnk_idx_r !== 1'b1) begin errorCount++; $display("[TB] FAIL flow_sort_ptr got %0d want 1", sort_bnk_idx_r); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCount++; if (deq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_deq_claimed got %0d want 0", deq_bnk_vld_r); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCount++; if (idle_r !== 1'b1) begin errorCount++; $display("[TB] FAIL flow_idle got %0d want 1", idle_r); end
    checkCount++; if (deq_bnk_idx_r !== 1'b1 || deq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_deq_next got idx %0d vld %0d want idx 1 vld 0", deq_bnk_idx_r, deq_bnk_vld_r); end
    checkCount++; if (proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL flow_proto got %0d want 0", proto_err_r); end
  endtask

  task automatic test_full_stall();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 6, 0, 0, 0, 0, 0, 0);
    checkCount++; if (enq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL full_enq_vld got %0d want 0", enq_bnk_vld_r); end
    checkCount++; if (enq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL full_enq_wrap got %0d want 0", enq_bnk_idx_r); end
    checkCount++; if (proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL full_proto_before got %0d want 0", proto_err_r); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCount++; if (proto_err_r !== 1'b1) begin errorCount++; $display("[TB] FAIL stall_start_proto got %0d want 1", proto_err_r); end
    checkCount++; if (enq_bnk_vld_r !== 1'b0 || enq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL stall_enq_state got vld %0d idx %0d want vld 0 idx 0", enq_bnk_vld_r, enq_bnk_idx_r); end
    checkCount++; if (sort_bnk_vld_r !== 1'b1 || sort_bnk_n_r !== 4'd4) begin errorCount++; $display("[TB] FAIL stall_bank0_loaded got vld %0d n %0d want vld 1 n 4", sort_bnk_vld_r, sort_bnk_n_r); end
    tick();
    checkCount++; if (proto_err_r !== 1'b1) begin errorCount++; $display("[TB] FAIL stall_proto_sticky got %0d want 1", proto_err_r); end
  endtask

  task automatic test_same_stage_violation();
    doReset();
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0);
    checkCount++; if (proto_err_r !== 1'b1) begin errorCount++; $display("[TB] FAIL startdone_proto got %0d want 1", proto_err_r); end
    checkCount++; if (enq_bnk_vld_r !== 1'b1 || idle_r !== 1'b1) begin errorCount++; $display("[TB] FAIL startdone_nochange got vld %0d idle %0d want vld 1 idle 1", enq_bnk_vld_r, idle_r); end
  endtask

  task automatic test_err_accum();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkCount++; if (deq_bnk_vld_r !== 1'b1 || deq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL err_b0_offer got vld %0d idx %0d want vld 1 idx 0", deq_bnk_vld_r, deq_bnk_idx_r); end
    checkCount++; if (deq_bnk_err_r !== 1'b1) begin errorCount++; $display("[TB] FAIL err_b0_enq_err got %0d want 1", deq_bnk_err_r); end
    checkCount++; if (deq_bnk_n_r !== 4'd5) begin errorCount++; $display("[TB] FAIL err_b0_n got %0d want 5", deq_bnk_n_r); end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCount++; if (deq_bnk_vld_r !== 1'b1 || deq_bnk_idx_r !== 1'b1) begin errorCount++; $display("[TB] FAIL err_b1_offer got vld %0d idx %0d want vld 1 idx 1", deq_bnk_vld_r, deq_bnk_idx_r); end
    checkCount++; if (deq_bnk_err_r !== 1'b1) begin errorCount++; $display("[TB] FAIL err_b1_sort_err got %0d want 1", deq_bnk_err_r); end
    checkCount++; if (deq_bnk_n_r !== 4'd7) begin errorCount++; $display("[TB] FAIL err_b1_n got %0d want 7", deq_bnk_n_r); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCount++; if (deq_bnk_vld_r !== 1'b0 || idle_r !== 1'b1) begin errorCount++; $display("[TB] FAIL err_empty got vld %0d idle %0d want vld 0 idle 1", deq_bnk_vld_r, idle_r); end
    checkCount++; if (deq_bnk_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL err_b0_cleared got %0d want 0", deq_bnk_err_r); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCount++; if (deq_bnk_idx_r !== 1'b1 || deq_bnk_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL err_b1_cleared got idx %0d err %0d want idx 1 err 0", deq_bnk_idx_r, deq_bnk_err_r); end
    checkCount++; if (proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL err_proto got %0d want 0", proto_err_r); end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 9, 0, 0, 1, 0, 0, 0);
    checkCount++; if (sort_bnk_vld_r !== 1'b1 || sort_bnk_idx_r !== 1'b1 || sort_bnk_n_r !== 4'd9) begin errorCount++; $display("[TB] FAIL b2b_a_sort got vld %0d idx %0d n %0d want 1 1 9", sort_bnk_vld_r, sort_bnk_idx_r, sort_bnk_n_r); end
    checkCount++; if (deq_bnk_vld_r !== 1'b1 || deq_bnk_idx_r !== 1'b0 || deq_bnk_n_r !== 4'd3) begin errorCount++; $display("[TB] FAIL b2b_a_deq got vld %0d idx %0d n %0d want 1 0 3", deq_bnk_vld_r, deq_bnk_idx_r, deq_bnk_n_r); end
    checkCount++; if (enq_bnk_vld_r !== 1'b0 || enq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_a_enq got vld %0d idx %0d want 0 0", enq_bnk_vld_r, enq_bnk_idx_r); end
    checkCount++; if (proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_a_proto got %0d want 0", proto_err_r); end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
    checkCount++; if (sort_bnk_vld_r !== 1'b0 || deq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_b_claims got sort %0d deq %0d want 0 0", sort_bnk_vld_r, deq_bnk_vld_r); end
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1);
    checkCount++; if (deq_bnk_vld_r !== 1'b1 || deq_bnk_idx_r !== 1'b1 || deq_bnk_n_r !== 4'd9 || deq_bnk_err_r !== 1'b1) begin errorCount++; $display("[TB] FAIL b2b_c_deq got vld %0d idx %0d n %0d err %0d want 1 1 9 1", deq_bnk_vld_r, deq_bnk_idx_r, deq_bnk_n_r, deq_bnk_err_r); end
    checkCount++; if (enq_bnk_vld_r !== 1'b1 || sort_bnk_vld_r !== 1'b0 || sort_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_c_other got enq %0d sort %0d sidx %0d want 1 0 0", enq_bnk_vld_r, sort_bnk_vld_r, sort_bnk_idx_r); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCount++; if (enq_bnk_vld_r !== 1'b0 || deq_bnk_vld_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_d_claims got enq %0d deq %0d want 0 0", enq_bnk_vld_r, deq_bnk_vld_r); end
    applyStimulus(0, 1, 2, 0, 0, 0, 0, 0, 1);
    checkCount++; if (enq_bnk_vld_r !== 1'b1 || enq_bnk_idx_r !== 1'b1) begin errorCount++; $display("[TB] FAIL b2b_e_enq got vld %0d idx %0d want 1 1", enq_bnk_vld_r, enq_bnk_idx_r); end
    checkCount++; if (deq_bnk_vld_r !== 1'b0 || deq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_e_deq got vld %0d idx %0d want 0 0", deq_bnk_vld_r, deq_bnk_idx_r); end
    checkCount++; if (sort_bnk_vld_r !== 1'b1 || sort_bnk_n_r !== 4'd2) begin errorCount++; $display("[TB] FAIL b2b_e_sort got vld %0d n %0d want 1 2", sort_bnk_vld_r, sort_bnk_n_r); end
    checkCount++; if (proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_proto got %0d want 0", proto_err_r); end
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 12, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCount++; if (proto_err_r !== 1'b1 || sort_bnk_n_r !== 4'd12 || enq_bnk_idx_r !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_before got proto %0d sn %0d eidx %0d want 1 12 1", proto_err_r, sort_bnk_n_r, enq_bnk_idx_r); end
    rst = 1'b1;
    tick();
    checkCount++; if (enq_bnk_vld_r !== 1'b1 || enq_bnk_idx_r !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_enq got vld %0d idx %0d want 1 0", enq_bnk_vld_r, enq_bnk_idx_r); end
    checkCount++; if (sort_bnk_vld_r !== 1'b0 || sort_bnk_idx_r !== 1'b0 || sort_bnk_n_r !== 4'd0) begin errorCount++; $display("[TB] FAIL mid_sort got vld %0d idx %0d n %0d want 0 0 0", sort_bnk_vld_r, sort_bnk_idx_r, sort_bnk_n_r); end
    checkCount++; if (deq_bnk_vld_r !== 1'b0 || deq_bnk_idx_r !== 1'b0 || deq_bnk_n_r !== 4'd0 || deq_bnk_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_deq got vld %0d idx %0d n %0d err %0d want 0 0 0 0", deq_bnk_vld_r, deq_bnk_idx_r, deq_bnk_n_r, deq_bnk_err_r); end
    checkCount++; if (idle_r !== 1'b1 || proto_err_r !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_status got idle %0d proto %0d want 1 0", idle_r, proto_err_r); end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkCount++; if (proto_err_r !== 1'b1 || idle_r !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_after_sort_start got proto %0d idle %0d want 1 1", proto_err_r, idle_r); end
  endtask

  // Run every scenario in order and report the totals.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    enq_start = 1'b0; enq_done = 1'b0; enq_n = '0; enq_err = 1'b0;
    sort_start = 1'b0; sort_done = 1'b0; sort_err = 1'b0;
    deq_start = 1'b0; deq_done = 1'b0;
    test_reset();
    test_single_flow();
    test_full_stall();
    test_same_stage_violation();
    test_err_accum();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
